// File: rtl/id_queue_stage_pkg.sv
// Shared encodings, decode-bundle type and helpers for the ID queue stage.
// Register tags are {fp_bank, idx[4:0]}; tag 0 (integer x0) is never a real dependency.
package id_queue_stage_pkg;

  localparam int TAG_W = 6;
  localparam logic [TAG_W-1:0] ZERO_REG = '0;

  // Major opcodes
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_IMM     = 7'b0010011;
  localparam logic [6:0] OP_REG     = 7'b0110011;
  localparam logic [6:0] OP_LOADFP  = 7'b0000111;
  localparam logic [6:0] OP_STOREFP = 7'b0100111;
  localparam logic [6:0] OP_FP      = 7'b1010011;

  // funct7 values
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;
  localparam logic [6:0] F7_FADD = 7'b0000000;
  localparam logic [6:0] F7_FSUB = 7'b0000100;
  localparam logic [6:0] F7_FMUL = 7'b0001000;
  localparam logic [6:0] F7_FDIV = 7'b0001100;

  // ALU functions; the M-extension group is ALU_MUL | funct3
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;
  localparam logic [4:0] ALU_FADD = 5'd10;
  localparam logic [4:0] ALU_FSUB = 5'd11;
  localparam logic [4:0] ALU_FMUL = 5'd12;
  localparam logic [4:0] ALU_FDIV = 5'd13;
  localparam logic [4:0] ALU_MUL  = 5'd16;

  // Memory commands: MSB=0 load (except MEM_NONE), MSB=1 store
  localparam logic [3:0] MEM_LB   = 4'b0000;
  localparam logic [3:0] MEM_LH   = 4'b0001;
  localparam logic [3:0] MEM_LW   = 4'b0010;
  localparam logic [3:0] MEM_FLW  = 4'b0011;
  localparam logic [3:0] MEM_LBU  = 4'b0100;
  localparam logic [3:0] MEM_LHU  = 4'b0101;
  localparam logic [3:0] MEM_NONE = 4'b0111;
  localparam logic [3:0] MEM_SB   = 4'b1000;
  localparam logic [3:0] MEM_SH   = 4'b1001;
  localparam logic [3:0] MEM_SW   = 4'b1010;
  localparam logic [3:0] MEM_FSW  = 4'b1011;

  // Branch control = {enable, type}
  localparam logic       FALSE   = 1'b0;
  localparam logic       TRUE    = 1'b1;
  localparam logic [2:0] BR_DONT = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_LT   = 3'd3;
  localparam logic [2:0] BR_GE   = 3'd4;
  localparam logic [2:0] BR_LTU  = 3'd5;
  localparam logic [2:0] BR_GEU  = 3'd6;
  localparam logic [2:0] BR_JUMP = 3'd7;

  // Operand selects
  localparam logic [1:0] SEL_CONST = 2'd0;
  localparam logic [1:0] SEL_REG   = 2'd1;
  localparam logic [1:0] SEL_PC    = 2'd2;
  localparam logic [1:0] SEL_IMM   = 2'd3;

  typedef struct packed {
    logic [TAG_W-1:0] rs1;
    logic [TAG_W-1:0] rs2;
    logic [TAG_W-1:0] rd;
    logic [31:0]      imm;
    logic [1:0]       opa_sel;
    logic [1:0]       opb_sel;
    logic [3:0]       br_ctrl;
    logic [4:0]       alu_func;
    logic [3:0]       mem_cmd;
    logic             illegal;
  } dec_t;

  localparam dec_t DEC_NOP = '{rs1: ZERO_REG, rs2: ZERO_REG, rd: ZERO_REG, imm: 32'd0,
                               opa_sel: SEL_CONST, opb_sel: SEL_CONST,
                               br_ctrl: {FALSE, BR_DONT}, alu_func: ALU_ADD,
                               mem_cmd: MEM_NONE, illegal: 1'b0};

  function automatic logic is_load(input logic [3:0] mem_cmd);
    return !mem_cmd[3] && (mem_cmd != MEM_NONE);
  endfunction

endpackage

// File: rtl/id_queue_stage_decoder.sv
// Purely combinational RV32IMF decoder: instruction word -> decode bundle.
// Latency: 0 cycles. Backpressure: none (no state).
// Ports: inst (32b instruction word) in, dec (decode bundle) out.
module rv_decoder
  import id_queue_stage_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic [TAG_W-1:0] x_rs1, x_rs2, x_rd, f_rs1, f_rs2, f_rd;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign i_imm = {{20{inst[31]}}, inst[31:20]};
  assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm = {inst[31:12], 12'd0};
  assign j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign x_rs1 = {1'b0, inst[19:15]};
  assign x_rs2 = {1'b0, inst[24:20]};
  assign x_rd  = {1'b0, inst[11:7]};
  assign f_rs1 = {1'b1, inst[19:15]};
  assign f_rs2 = {1'b1, inst[24:20]};
  assign f_rd  = {1'b1, inst[11:7]};

  function automatic logic [4:0] base_alu(input logic [2:0] fn);
    case (fn)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Unused source fields stay ZERO_REG so they can never raise a false hazard.
  always_comb begin
    dec = DEC_NOP;
    case (opc)
      OP_LUI: begin
        dec.rd = x_rd; dec.imm = u_imm; dec.opb_sel = SEL_IMM;
      end
      OP_AUIPC: begin
        dec.rd = x_rd; dec.imm = u_imm; dec.opa_sel = SEL_PC; dec.opb_sel = SEL_IMM;
      end
      OP_JAL: begin
        dec.rd = x_rd; dec.imm = j_imm; dec.opa_sel = SEL_PC; dec.br_ctrl = {TRUE, BR_JUMP};
      end
      OP_JALR: begin
        dec.rd = x_rd; dec.rs1 = x_rs1; dec.imm = i_imm; dec.opa_sel = SEL_REG;
        dec.br_ctrl = {TRUE, BR_JUMP};
        dec.illegal = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        dec.rs1 = x_rs1; dec.rs2 = x_rs2; dec.imm = b_imm;
        dec.opa_sel = SEL_PC; dec.opb_sel = SEL_IMM; dec.alu_func = ALU_SUB;
        case (f3)
          3'b000:  dec.br_ctrl = {TRUE, BR_EQ};
          3'b001:  dec.br_ctrl = {TRUE, BR_NE};
          3'b100:  dec.br_ctrl = {TRUE, BR_LT};
          3'b101:  dec.br_ctrl = {TRUE, BR_GE};
          3'b110:  dec.br_ctrl = {TRUE, BR_LTU};
          3'b111:  dec.br_ctrl = {TRUE, BR_GEU};
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.rd = x_rd; dec.rs1 = x_rs1; dec.imm = i_imm;
        dec.opa_sel = SEL_REG; dec.opb_sel = SEL_IMM;
        case (f3)
          3'b000:  dec.mem_cmd = MEM_LB;
          3'b001:  dec.mem_cmd = MEM_LH;
          3'b010:  dec.mem_cmd = MEM_LW;
          3'b100:  dec.mem_cmd = MEM_LBU;
          3'b101:  dec.mem_cmd = MEM_LHU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        dec.rs1 = x_rs1; dec.rs2 = x_rs2; dec.imm = s_imm;
        dec.opa_sel = SEL_REG; dec.opb_sel = SEL_IMM;
        case (f3)
          3'b000:  dec.mem_cmd = MEM_SB;
          3'b001:  dec.mem_cmd = MEM_SH;
          3'b010:  dec.mem_cmd = MEM_SW;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec.rd = x_rd; dec.rs1 = x_rs1; dec.imm = i_imm;
        dec.opa_sel = SEL_REG; dec.opb_sel = SEL_IMM;
        dec.alu_func = base_alu(f3);
        // Only the shift forms constrain funct7; other forms use those bits as immediate.
        if (f3 == 3'b101 && f7 == F7_ALT) dec.alu_func = ALU_SRA;
        dec.illegal = (f3 == 3'b001 && f7 != F7_BASE) ||
                      (f3 == 3'b101 && f7 != F7_BASE && f7 != F7_ALT);
      end
      OP_REG: begin
        dec.rd = x_rd; dec.rs1 = x_rs1; dec.rs2 = x_rs2;
        dec.opa_sel = SEL_REG; dec.opb_sel = SEL_REG;
        case (f7)
          F7_BASE: dec.alu_func = base_alu(f3);
          F7_MUL:  dec.alu_func = ALU_MUL | {2'b00, f3};
          F7_ALT: begin
            if (f3 == 3'b000)      dec.alu_func = ALU_SUB;
            else if (f3 == 3'b101) dec.alu_func = ALU_SRA;
            else                   dec.illegal  = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_LOADFP: begin
        dec.rd = f_rd; dec.rs1 = x_rs1; dec.imm = i_imm;
        dec.opa_sel = SEL_REG; dec.opb_sel = SEL_IMM; dec.mem_cmd = MEM_FLW;
        dec.illegal = (f3 != 3'b010);
      end
      OP_STOREFP: begin
        dec.rs1 = x_rs1; dec.rs2 = f_rs2; dec.imm = s_imm;
        dec.opa_sel = SEL_REG; dec.opb_sel = SEL_IMM; dec.mem_cmd = MEM_FSW;
        dec.illegal = (f3 != 3'b010);
      end
      OP_FP: begin
        dec.rd = f_rd; dec.rs1 = f_rs1; dec.rs2 = f_rs2;
        dec.opa_sel = SEL_REG; dec.opb_sel = SEL_REG;
        case (f7)
          F7_FADD: dec.alu_func = ALU_FADD;
          F7_FSUB: dec.alu_func = ALU_FSUB;
          F7_FMUL: dec.alu_func = ALU_FMUL;
          F7_FDIV: dec.alu_func = ALU_FDIV;
          default: dec.illegal  = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
    // An illegal bundle must not write, access memory or redirect.
    if (dec.illegal) begin
      dec.rd      = ZERO_REG;
      dec.mem_cmd = MEM_NONE;
      dec.br_ctrl = {FALSE, BR_DONT};
    end
  end

endmodule

// File: rtl/id_queue_stage.sv
// Decode stage: instruction FIFO, head decode, load-use hazard stall, forwarding selects.
// Latency: push-to-out_vld 2 edges when the queue is empty and EX is ready.
// Backpressure: in_rdy low only when the queue is full; out_rdy low freezes the output register.
// Ports: in_* fetch side (vld/rdy), flush redirect, ex_ld_* load in EX, fwd_* downstream rd tags,
//        out_* registered decode bundle (vld/rdy), stall_cnt saturating hazard-stall count.
module id_queue_stage
  import id_queue_stage_pkg::*;
#(
  parameter  int QDEPTH     = 4,
  parameter  int FWD_STAGES = 2,
  parameter  int REG_W      = TAG_W,
  parameter  int CNT_W      = 16,
  localparam int FSEL_W     = $clog2(FWD_STAGES + 2)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_vld,
  output logic                        in_rdy,
  input  logic [31:0]                 in_pc,
  input  logic [31:0]                 in_inst,
  input  logic                        flush,
  input  logic                        ex_ld_vld,
  input  logic [REG_W-1:0]            ex_ld_rd,
  input  logic [FWD_STAGES-1:0]       fwd_vld,
  input  logic [FWD_STAGES*REG_W-1:0] fwd_rd,
  output logic                        out_vld,
  input  logic                        out_rdy,
  output logic [31:0]                 out_pc,
  output logic [REG_W-1:0]            out_rs1,
  output logic [REG_W-1:0]            out_rs2,
  output logic [REG_W-1:0]            out_rd,
  output logic [31:0]                 out_imm,
  output logic [1:0]                  out_opa_sel,
  output logic [1:0]                  out_opb_sel,
  output logic [FSEL_W-1:0]           out_fwd1,
  output logic [FSEL_W-1:0]           out_fwd2,
  output logic [3:0]                  out_br_ctrl,
  output logic [4:0]                  out_alu_func,
  output logic [3:0]                  out_mem_cmd,
  output logic                        out_illegal,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] Q_FULL = CW'(QDEPTH);

  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_inst [QDEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, issue, head_vld, hazard, out_is_ld;
  dec_t          hd, out_q;
  logic [FSEL_W-1:0] fsel1, fsel2;

  assign in_rdy   = (count != Q_FULL);
  assign push     = in_vld && in_rdy && !flush;
  assign head_vld = (count != '0);

  rv_decoder u_dec (
    .inst (q_inst[rd_ptr]),
    .dec  (hd)
  );

  function automatic logic tag_hit(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
    return (src != ZERO_REG) && (src == dst);
  endfunction

  // Candidates are applied from highest to lowest select so the lowest match wins.
  function automatic logic [FSEL_W-1:0] fwd_sel(input logic [REG_W-1:0] src);
    logic [FSEL_W-1:0] sel;
    sel = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (fwd_vld[k] && tag_hit(src, fwd_rd[k*REG_W +: REG_W])) sel = FSEL_W'(k + 2);
    end
    if (out_vld && tag_hit(src, out_q.rd)) sel = FSEL_W'(1);
    return sel;
  endfunction

  assign out_is_ld = out_vld && is_load(out_q.mem_cmd);
  assign hazard = head_vld &&
                  ((ex_ld_vld && (tag_hit(hd.rs1, ex_ld_rd) || tag_hit(hd.rs2, ex_ld_rd))) ||
                   (out_is_ld && (tag_hit(hd.rs1, out_q.rd) || tag_hit(hd.rs2, out_q.rd))));
  assign issue  = head_vld && !hazard && !flush && (!out_vld || out_rdy);
  assign fsel1  = fwd_sel(hd.rs1);
  assign fsel2  = fwd_sel(hd.rs2);

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= in_pc;
      q_inst[wr_ptr] <= in_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_vld   <= 1'b0;
      out_pc    <= '0;
      out_q     <= DEC_NOP;
      out_fwd1  <= '0;
      out_fwd2  <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        out_vld <= 1'b0;
      end else begin
        if (push)  wr_ptr <= wr_ptr + PW'(1);
        if (issue) rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(issue);
        if (issue) begin
          out_vld  <= 1'b1;
          out_pc   <= q_pc[rd_ptr];
          out_q    <= hd;
          out_fwd1 <= fsel1;
          out_fwd2 <= fsel2;
        end else if (out_rdy) begin
          out_vld <= 1'b0;
        end
      end
      if (hazard && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_rd       = out_q.rd;
  assign out_imm      = out_q.imm;
  assign out_opa_sel  = out_q.opa_sel;
  assign out_opb_sel  = out_q.opb_sel;
  assign out_br_ctrl  = out_q.br_ctrl;
  assign out_alu_func = out_q.alu_func;
  assign out_mem_cmd  = out_q.mem_cmd;
  assign out_illegal  = out_q.illegal;

endmodule
